// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time,
// and buffers returned words in a small FIFO presented to decode.
module fetch_unit #(
  parameter int unsigned           INST_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  system_stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic [INST_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q;
  logic                  drop_q, drop_d;
  logic                  granted;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] redir_pc;

  logic [INST_WIDTH-1:0] buf_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count;

  assign redir_pc = redirect_pc & ~ADDR_WIDTH'(3);
  assign pop      = inst_valid & ~system_stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    granted = 1'b0;
    push    = 1'b0;
    case (state_q)
      // Only issue when the FIFO has room; nothing else can be pushed until this
      // request's response, so a response never meets a full buffer.
      S_IDLE: if (!redirect_valid && (count < CNT_W'(FIFO_DEPTH))) state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          granted = 1'b1;
          state_d = S_WAIT;
          pc_d    = pc_q + ADDR_WIDTH'(4);
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          push    = !drop_q && !redirect_valid;
          state_d = S_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) begin
      pc_d = redir_pc;
      // A grant still owes us a response: keep waiting for it, but throw it away.
      if (granted || (state_q == S_WAIT && !imem_rsp_valid)) begin
        state_d = S_WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = S_IDLE;
        drop_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      if (granted) req_pc_q <= pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= imem_rsp_data;
      buf_pc[wr_ptr]   <= req_pc_q;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign inst_valid  = (count != '0);
  assign instruction = inst_valid ? buf_data[rd_ptr] : NOP;
  assign inst_pc     = inst_valid ? buf_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a memory model queues expected words as it
// answers requests, and a monitor checks every word decode consumes.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, system_stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data;
  logic [31:0] instruction, inst_pc;
  logic        inst_valid;

  logic        stall2, redirect2, req2, gnt2, rsp_valid2, iv2;
  logic [31:0] redirect_pc2, addr2, rsp_data2, instr2, ipc2;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] addr_log[$];
  logic        gnt_en, rsp_hold, pend, acc, acc2;
  logic [31:0] pend_addr, acc_addr;
  int          discard_cnt;
  logic [31:0] log2[2];
  int          n2 = 0;

  fetch_unit #(.INST_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .system_stall(system_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instruction(instruction), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  fetch_unit #(.INST_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset), .system_stall(stall2),
    .redirect_valid(redirect2), .redirect_pc(redirect_pc2),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
    .instruction(instr2), .inst_pc(ipc2), .inst_valid(iv2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0010_0113;
      32'h0000_0008: return 32'h0020_0193;
      32'h0000_000C: return 32'h0030_0213;
      32'h0000_0100: return 32'h00A0_0293;
      default:       return {a[23:0], 8'h13};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_log(input string name, input int n);
    int k = 0;
    while (addr_log.size() < n && k < 60) begin
      cyc(1);
      k++;
    end
    if (addr_log.size() < n) timeout(name);
  endtask

  task automatic wait_pend(input string name);
    int k = 0;
    while (!pend && k < 60) begin
      cyc(1);
      k++;
    end
    if (!pend) timeout(name);
  endtask

  // Memory model: grant follows gnt_en, response one cycle after the grant edge.
  always @(negedge clk) begin
    acc      = reset && imem_req && imem_gnt;
    acc_addr = imem_addr;
    if (acc) addr_log.push_back(imem_addr);
  end

  always @(posedge clk) begin
    #1;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = acc_addr;
      acc       = 1'b0;
    end
    if (pend && !rsp_hold) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr);
      pend           = 1'b0;
      if (discard_cnt > 0) discard_cnt--;
      else exp_q.push_back({mem_word(pend_addr), pend_addr});
    end
    imem_gnt = gnt_en && imem_req;
  end

  // Scoreboard monitor: every word decode consumes must be the next expected one.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset && inst_valid && !system_stall) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_inst: got pc %h instr %h, required inst_valid=0", inst_pc, instruction);
      end else begin
        e = exp_q.pop_front();
        chk("inst_data", instruction, e[63:32]);
        chk("inst_pc", inst_pc, e[31:0]);
      end
    end
  end

  // Second instance only exercises PC wrap from the top of the address space.
  always @(negedge clk) begin
    acc2 = reset && req2 && gnt2;
    if (acc2 && n2 < 2) begin
      log2[n2] = addr2;
      n2++;
    end
  end

  always @(posedge clk) begin
    #1;
    rsp_valid2 = acc2;
    gnt2       = req2;
  end

  initial begin
    logic [31:0] a0, last;
    logic [63:0] head;
    reset = 1'b0; system_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    gnt_en = 1'b1; rsp_hold = 1'b0; pend = 1'b0; acc = 1'b0; discard_cnt = 0;
    stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0; gnt2 = 1'b0;
    rsp_valid2 = 1'b0; rsp_data2 = 32'h0000_0013; acc2 = 1'b0;
    cyc(2);

    // Reset values
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_addr_wrap", addr2, 32'hFFFF_FFFC);
    chk("rst_wrap_outs", {instr2[30:0], iv2}, {31'h13, 1'b0});
    chk("rst_wrap_pc", ipc2, 32'h0);

    // 1: first request on the first edge after release, sequential addresses
    reset = 1'b1;
    addr_log.delete();
    cyc(1);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    wait_log("seq_addr", 3);
    if (addr_log.size() >= 3) begin
      chk("seq_addr0", addr_log[0], 32'h0);
      chk("seq_addr1", addr_log[1], 32'h4);
      chk("seq_addr2", addr_log[2], 32'h8);
    end

    // 5: wrap of the second instance
    if (n2 >= 2) begin
      chk("wrap_addr0", log2[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", log2[1], 32'h0);
    end else timeout("wrap_addr");

    // 2: stall fills the FIFO, requests stop, head held
    system_stall = 1'b1;
    cyc(10);
    chk("stall_valid", 32'(inst_valid), 32'd1);
    chk("stall_req", 32'(imem_req), 32'd0);
    if (exp_q.size() > 0 && addr_log.size() > 0) begin
      head = exp_q[0];
      chk("stall_head_data", instruction, head[63:32]);
      chk("stall_head_pc", inst_pc, head[31:0]);
      last = addr_log[addr_log.size()-1];
      addr_log.delete();
      system_stall = 1'b0;
      wait_log("resume_addr", 1);
      if (addr_log.size() >= 1) chk("resume_addr", addr_log[0], last + 32'd4);
    end else begin
      timeout("stall_fill");
      system_stall = 1'b0;
    end
    cyc(4);

    // 3: redirect while a response is outstanding
    rsp_hold = 1'b1;
    wait_pend("reach_wait");
    system_stall   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    cyc(1);
    redirect_valid = 1'b0;
    system_stall   = 1'b0;
    exp_q.delete();
    addr_log.delete();
    discard_cnt    = 1;
    rsp_hold       = 1'b0;
    chk("redir_flush", 32'(inst_valid), 32'd0);
    wait_log("redir_addr", 1);
    if (addr_log.size() >= 1) chk("redir_addr", addr_log[0], 32'h0000_0100);
    cyc(6);

    // 4: grant withheld, request and address hold steady
    gnt_en = 1'b0;
    begin
      int k = 0;
      while (!(imem_req && !imem_gnt) && k < 20) begin
        cyc(1);
        k++;
      end
    end
    a0 = imem_addr;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("hold_req", 32'(imem_req), 32'd1);
      chk("hold_addr", imem_addr, a0);
    end
    addr_log.delete();
    gnt_en = 1'b1;
    wait_log("hold_release", 2);
    if (addr_log.size() >= 2) begin
      chk("hold_gnt_addr", addr_log[0], a0);
      chk("hold_next_addr", addr_log[1], a0 + 32'd4);
    end

    // 6: reset while waiting; the late response must be ignored
    rsp_hold = 1'b1;
    wait_pend("reach_wait2");
    reset  = 1'b0;
    gnt_en = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_addr", imem_addr, 32'h0);
    cyc(2);
    reset       = 1'b1;
    discard_cnt = 1;
    rsp_hold    = 1'b0;
    addr_log.delete();
    cyc(4);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_valid", 32'(inst_valid), 32'd0);
    gnt_en = 1'b1;
    wait_log("post_rst_fetch", 1);
    if (addr_log.size() >= 1) chk("post_rst_fetch", addr_log[0], 32'h0);

    // Let everything in flight drain and be consumed
    cyc(4);
    gnt_en = 1'b0;
    cyc(12);
    chk("drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
